// File: rtl/ex_mem_stage_reg.sv
// EX/MEM pipeline register: captures execute-stage results on the falling clock edge,
// with flush/stall control and saturating stall/flush event counters.
module ex_mem_stage_reg #(
    parameter int DATA_W = 32,
    parameter int RD_W   = 5,
    parameter int CTRL_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              valid_in,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic [DATA_W-1:0] alu_result_in,
    input  logic [DATA_W-1:0] store_data_in,
    input  logic [RD_W-1:0]   rd_in,
    input  logic              flag_in,
    output logic              valid_out,
    output logic [CTRL_W-1:0] ctrl_out,
    output logic [DATA_W-1:0] alu_result_out,
    output logic [DATA_W-1:0] store_data_out,
    output logic [RD_W-1:0]   rd_out,
    output logic              flag_out,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  flush_count,
    output logic              bubble_out
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic              vld_p1;
    logic [CTRL_W-1:0] ctrl_p1;
    logic [DATA_W-1:0] alu_result_p1;
    logic [DATA_W-1:0] store_data_p1;
    logic [RD_W-1:0]   rd_p1;
    logic              flag_p1;
    logic              bubble_p1;
    logic [CNT_W-1:0]  stall_cnt_p1;
    logic [CNT_W-1:0]  flush_cnt_p1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    // EX -> MEM boundary: reset > flush > stall > load, captured on the falling edge
    always_ff @(negedge clock) begin
        if (reset) begin
            vld_p1        <= 1'b0;
            ctrl_p1       <= '0;
            alu_result_p1 <= '0;
            store_data_p1 <= '0;
            rd_p1         <= '0;
            flag_p1       <= 1'b0;
            bubble_p1     <= 1'b0;
            stall_cnt_p1  <= '0;
            flush_cnt_p1  <= '0;
        end else if (flush) begin
            vld_p1        <= 1'b0;
            ctrl_p1       <= '0;
            alu_result_p1 <= '0;
            store_data_p1 <= '0;
            rd_p1         <= '0;
            flag_p1       <= 1'b0;
            bubble_p1     <= 1'b1;
            flush_cnt_p1  <= sat_inc(flush_cnt_p1);
        end else if (stall) begin
            stall_cnt_p1  <= sat_inc(stall_cnt_p1);
        end else begin
            vld_p1        <= valid_in;
            // An invalid slot must never carry active control into MEM.
            ctrl_p1       <= valid_in ? ctrl_in : '0;
            alu_result_p1 <= alu_result_in;
            store_data_p1 <= store_data_in;
            rd_p1         <= rd_in;
            flag_p1       <= flag_in;
            bubble_p1     <= 1'b0;
        end
    end

    assign valid_out      = vld_p1;
    assign ctrl_out       = ctrl_p1;
    assign alu_result_out = alu_result_p1;
    assign store_data_out = store_data_p1;
    assign rd_out         = rd_p1;
    assign flag_out       = flag_p1;
    assign bubble_out     = bubble_p1;
    assign stall_count    = stall_cnt_p1;
    assign flush_count    = flush_cnt_p1;

endmodule

// File: doc/ex_mem_stage_reg.md
EX_MEM_STAGE_REG -- requirements
Module: ex_mem_stage_reg

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning width of each of the two data lanes (ALU result, store data).
REQ-002 The block SHALL have parameter RD_W, default 5, meaning destination-register index width.
REQ-003 The block SHALL have parameter CTRL_W, default 5, meaning width of the packed control vector (WB and MEM control bits).
REQ-004 The block SHALL have parameter CNT_W, default 16, meaning width of the stall and flush event counters.
REQ-005 The block SHALL have one clock and a reset that is synchronous and active-high, with the ports named clock and reset.
REQ-006 The port list SHALL be as follows, one port per line (name, direction, width, meaning):
- clock  in  1  stage clock; all state is captured on its falling edge.
- reset  in  1  synchronous active-high reset.
- stall  in  1  hold the current contents.
- flush  in  1  insert a bubble.
- valid_in  in  1  the incoming instruction is real.
- ctrl_in  in  CTRL_W  control vector.
- alu_result_in  in  DATA_W  ALU result.
- store_data_in  in  DATA_W  store data.
- rd_in  in  RD_W  destination register index.
- flag_in  in  1  branch-compare flag.
- valid_out  out  1  registered valid.
- ctrl_out  out  CTRL_W  registered control vector.
- alu_result_out  out  DATA_W  registered ALU result.
- store_data_out  out  DATA_W  registered store data.
- rd_out  out  RD_W  registered destination index.
- flag_out  out  1  registered branch-compare flag.
- stall_count  out  CNT_W  count of stalled cycles.
- flush_count  out  CNT_W  count of flushed cycles.
- bubble_out  out  1  the last captured cycle was a flush.

Function
REQ-007 All registered outputs SHALL update only on the falling edge of clock, with a latency of one cycle from input to output.
REQ-008 Per-edge priority SHALL be reset > flush > stall > load.
REQ-009 On load (reset=0, flush=0, stall=0), the stage SHALL capture every *_in into its matching *_out and clear bubble_out.
REQ-010 On stall (reset=0, flush=0, stall=1), every payload output and valid_out SHALL hold its value, and bubble_out SHALL hold its value.
REQ-011 On flush (reset=0, flush=1), valid_out, ctrl_out, alu_result_out, store_data_out, rd_out and flag_out SHALL become zero, and bubble_out SHALL become 1, regardless of stall.
REQ-012 When valid_in=0 on a load, the stage SHALL force ctrl_out to zero and capture the remaining fields, so that an invalid slot never carries active control.
REQ-013 When valid_out=0, ctrl_out SHALL always be zero (invariant).
REQ-014 stall_count SHALL increment by 1 on each edge where stall=1, flush=0 and reset=0.
REQ-015 flush_count SHALL increment by 1 on each edge where flush=1 and reset=0, including when stall=1 is also asserted.
REQ-016 Both counters SHALL saturate at 2^CNT_W-1 and SHALL not wrap.
REQ-017 The block SHALL use no combinational path from any input to any output.
REQ-018 The block SHALL support RD_W >= 1, DATA_W >= 1, CTRL_W >= 1 and CNT_W >= 2 without change.

Reset
REQ-019 On a falling edge with reset=1, all outputs SHALL be set to zero, including stall_count, flush_count and bubble_out, irrespective of stall and flush.
REQ-020 Between power-up and the first reset edge, output values SHALL be undefined; the bench SHALL apply reset for at least 1 cycle.
REQ-021 An asserted reset during a stall SHALL discard the held contents and leave the stage empty; the next load after reset deasserts SHALL capture normally.

Verification
REQ-022 Load scenario: reset for 2 cycles, then valid_in=1, ctrl_in=5'b10110, alu_result_in=32'h0000_1234, rd_in=7 -> after one falling edge, ctrl_out=5'b10110, alu_result_out=32'h1234, rd_out=7, valid_out=1, and both counters 0.
REQ-023 Stall scenario: after REQ-022, hold stall=1 for 3 edges with inputs changed to alu_result_in=32'hDEAD_BEEF -> outputs remain 32'h1234 and stall_count=3; on release, the next edge loads 32'hDEADBEEF.
REQ-024 Flush-beats-stall scenario: stall=1 and flush=1 on one edge -> all payload outputs 0, bubble_out=1, flush_count=1, and stall_count unchanged.
REQ-025 Invalid-slot scenario: valid_in=0, ctrl_in=5'b11111, rd_in=3 -> ctrl_out=0, valid_out=0, rd_out=3.
REQ-026 Saturation scenario: CNT_W=2, stall held for 6 edges -> stall_count reads 1, 2, 3, 3, 3, 3.
REQ-027 Reset-mid-stall scenario: stall=1 with valid_out=1, then reset=1 for one edge -> all outputs 0; with reset=0, stall=0 and valid_in=1 on the next edge -> valid_out=1.
